// File: rtl/relogio_pkg.sv
// Shared types and constants for the factory time/production tracker.
package relogio_pkg;

  typedef enum logic [2:0] {
    DOMINGO = 3'd0,
    SEGUNDA = 3'd1,
    TERCA   = 3'd2,
    QUARTA  = 3'd3,
    QUINTA  = 3'd4,
    SEXTA   = 3'd5,
    SABADO  = 3'd6
  } dia_t;

  localparam int MIN_POR_HORA    = 60;
  localparam int HORAS_POR_DIA   = 24;
  localparam int DIAS_POR_SEMANA = 7;
  localparam logic [2:0] DIA_SEXTA = 3'(SEXTA);

  // Counter width that stays at least one bit for a modulo-1 counter.
  function automatic int largura(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_mod.sv
// Modulo-N counter with enable, range-checked synchronous load and carry out.
module contador_mod #(
  parameter int N = 2,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic [W-1:0] o_q,
  output logic         o_carry
);

  localparam logic [W:0]   LIMITE = (W+1)'(N);
  localparam logic [W-1:0] TOPO   = W'(N - 1);

  logic [W-1:0] r_q;
  logic         w_load_ok;

  assign w_load_ok = ({1'b0, i_load_val} < LIMITE);
  // A load cycle never propagates a carry, so loading cannot ripple upward.
  assign o_carry   = i_en & ~i_load & (r_q == TOPO);
  assign o_q       = r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      if (w_load_ok) r_q <= i_load_val;
    end else if (i_en) begin
      r_q <= (r_q == TOPO) ? '0 : r_q + W'(1);
    end
  end

endmodule

// File: rtl/relogio_fabrica.sv
// Minute/hour/weekday clock plus daily piece counter feeding the alarm flags.
module relogio_fabrica
  import relogio_pkg::*;
#(
  parameter int DIV_MIN       = 120,
  parameter int HORA_NOITE    = 18,
  parameter int META_PRODUCAO = 100,
  parameter int CW            = $clog2(META_PRODUCAO + 1)
) (
  input  logic          clk_2,
  input  logic          reset_n,
  input  logic          ajusta,
  input  logic [4:0]    hora_in,
  input  logic [5:0]    minuto_in,
  input  logic [2:0]    dia_in,
  input  logic          peca,
  output logic [4:0]    hora,
  output logic [5:0]    minuto,
  output logic [2:0]    dia,
  output logic [CW-1:0] contagem,
  output logic          noite,
  output logic          sexta,
  output logic          producao,
  output logic          virada_dia
);

  localparam int PW = largura(DIV_MIN);
  localparam logic [CW-1:0] META = CW'(META_PRODUCAO);

  logic [PW-1:0] w_unused_pre;
  logic          w_unused_carry_dia;
  logic          w_tick_min;
  logic          w_carry_min;
  logic          w_carry_hora;

  logic [CW-1:0] r_contagem;
  logic          r_virada;

  // Prescaler always reloads to zero on ajusta so the minute restarts cleanly.
  contador_mod #(.N(DIV_MIN), .W(PW)) u_pre (
    .i_clk(clk_2), .i_rst_n(reset_n), .i_en(1'b1), .i_load(ajusta),
    .i_load_val('0), .o_q(w_unused_pre), .o_carry(w_tick_min)
  );

  contador_mod #(.N(MIN_POR_HORA), .W(6)) u_min (
    .i_clk(clk_2), .i_rst_n(reset_n), .i_en(w_tick_min), .i_load(ajusta),
    .i_load_val(minuto_in), .o_q(minuto), .o_carry(w_carry_min)
  );

  contador_mod #(.N(HORAS_POR_DIA), .W(5)) u_hora (
    .i_clk(clk_2), .i_rst_n(reset_n), .i_en(w_carry_min), .i_load(ajusta),
    .i_load_val(hora_in), .o_q(hora), .o_carry(w_carry_hora)
  );

  contador_mod #(.N(DIAS_POR_SEMANA), .W(3)) u_dia (
    .i_clk(clk_2), .i_rst_n(reset_n), .i_en(w_carry_hora), .i_load(ajusta),
    .i_load_val(dia_in), .o_q(dia), .o_carry(w_unused_carry_dia)
  );

  // Hour carry is the midnight event; a piece on that edge counts for the new day.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      r_contagem <= '0;
      r_virada   <= 1'b0;
    end else begin
      r_virada <= w_carry_hora;
      if (w_carry_hora) begin
        r_contagem <= peca ? CW'(1) : '0;
      end else if (peca && (r_contagem < META)) begin
        r_contagem <= r_contagem + CW'(1);
      end
    end
  end

  assign contagem   = r_contagem;
  assign virada_dia = r_virada;
  assign noite      = (hora >= 5'(HORA_NOITE));
  assign sexta      = (dia == DIA_SEXTA);
  assign producao   = (r_contagem >= META);

endmodule

// File: tb/tb_relogio_fabrica.sv
// Scoreboard bench: a minute-of-week reference model predicts every cycle.
module tb_relogio_fabrica;

  localparam int DIV   = 2;
  localparam int NOITE = 18;
  localparam int META  = 3;
  localparam int MIN_DIA    = 24 * 60;
  localparam int MIN_SEMANA = 7 * MIN_DIA;

  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       ajusta = 1'b0;
  logic [4:0] hora_in = '0;
  logic [5:0] minuto_in = '0;
  logic [2:0] dia_in = '0;
  logic       peca = 1'b0;
  logic [4:0] hora;
  logic [5:0] minuto;
  logic [2:0] dia;
  logic [1:0] contagem;
  logic       noite, sexta, producao, virada_dia;

  relogio_fabrica #(
    .DIV_MIN(DIV), .HORA_NOITE(NOITE), .META_PRODUCAO(META)
  ) dut (
    .clk_2(clk_2), .reset_n(reset_n), .ajusta(ajusta), .hora_in(hora_in),
    .minuto_in(minuto_in), .dia_in(dia_in), .peca(peca), .hora(hora),
    .minuto(minuto), .dia(dia), .contagem(contagem), .noite(noite),
    .sexta(sexta), .producao(producao), .virada_dia(virada_dia)
  );

  always #5 clk_2 = ~clk_2;

  typedef struct {
    int hora, minuto, dia, contagem;
    int noite, sexta, producao, virada;
  } exp_t;

  exp_t sb[$];
  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: position in the week in minutes, prescaler phase, pieces today.
  int m_phase, m_tmin, m_cnt, m_virada;

  task automatic chk(input string nome, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tmin = 0; m_cnt = 0; m_virada = 0;
  endtask

  task automatic model_step(input bit aj, input int h, input int m, input int d, input bit p);
    int hh, mm, dd;
    bit meia;
    meia = 1'b0;
    if (aj) begin
      dd = m_tmin / MIN_DIA;
      hh = (m_tmin % MIN_DIA) / 60;
      mm = m_tmin % 60;
      if (h < 24) hh = h;
      if (m < 60) mm = m;
      if (d < 7)  dd = d;
      m_tmin  = dd * MIN_DIA + hh * 60 + mm;
      m_phase = 0;
    end else if (m_phase == DIV - 1) begin
      m_phase = 0;
      m_tmin  = (m_tmin + 1) % MIN_SEMANA;
      meia    = ((m_tmin % MIN_DIA) == 0);
    end else begin
      m_phase++;
    end
    m_virada = meia ? 1 : 0;
    if (meia) m_cnt = p ? 1 : 0;
    else if (p && m_cnt < META) m_cnt++;
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.dia      = m_tmin / MIN_DIA;
    e.hora     = (m_tmin % MIN_DIA) / 60;
    e.minuto   = m_tmin % 60;
    e.contagem = m_cnt;
    e.noite    = (e.hora >= NOITE) ? 1 : 0;
    e.sexta    = (e.dia == 5) ? 1 : 0;
    e.producao = (m_cnt >= META) ? 1 : 0;
    e.virada   = m_virada;
    return e;
  endfunction

  task automatic step(input bit aj, input int h, input int m, input int d, input bit p);
    ajusta = aj; hora_in = 5'(h); minuto_in = 6'(m); dia_in = 3'(d); peca = p;
    @(posedge clk_2);
    model_step(aj, h, m, d, p);
    sb.push_back(expected());
    #2;
    ajusta = 1'b0; peca = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_hora"}, int'(hora), 0);
    chk({tag, "_minuto"}, int'(minuto), 0);
    chk({tag, "_dia"}, int'(dia), 0);
    chk({tag, "_contagem"}, int'(contagem), 0);
    chk({tag, "_noite"}, int'(noite), 0);
    chk({tag, "_sexta"}, int'(sexta), 0);
    chk({tag, "_producao"}, int'(producao), 0);
    chk({tag, "_virada"}, int'(virada_dia), 0);
  endtask

  // Monitor: one expected snapshot per clock edge, compared on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_2);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_hora", int'(hora), e.hora);
        chk("sb_minuto", int'(minuto), e.minuto);
        chk("sb_dia", int'(dia), e.dia);
        chk("sb_contagem", int'(contagem), e.contagem);
        chk("sb_noite", int'(noite), e.noite);
        chk("sb_sexta", int'(sexta), e.sexta);
        chk("sb_producao", int'(producao), e.producao);
        chk("sb_virada", int'(virada_dia), e.virada);
        $display("cycle t=%0t %02d:%02d dia=%0d cnt=%0d n=%0d s=%0d p=%0d v=%0d",
                 $time, hora, minuto, dia, contagem, noite, sexta, producao, virada_dia);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    #1 check_zero("reset");
    #11 reset_n = 1'b1;

    idle(); idle();
    chk("first_minute", int'(minuto), 1);
    idle(); idle();
    chk("second_minute", int'(minuto), 2);

    step(1'b1, 17, 59, 5, 1'b0);
    chk("load_sexta", int'(sexta), 1);
    chk("load_noite", int'(noite), 0);
    idle(); idle();
    chk("hora_18", int'(hora), 18);
    chk("noite_18", int'(noite), 1);

    repeat (3) step(1'b0, 0, 0, 0, 1'b1);
    chk("producao_meta", int'(producao), 1);
    step(1'b1, 23, 59, 6, 1'b0);
    idle();
    chk("pre_midnight_hora", int'(hora), 23);
    idle();
    chk("midnight_dia", int'(dia), 0);
    chk("midnight_virada", int'(virada_dia), 1);
    chk("midnight_contagem", int'(contagem), 0);
    idle();
    chk("virada_one_cycle", int'(virada_dia), 0);

    step(1'b1, 23, 59, 2, 1'b0);
    idle();
    step(1'b0, 0, 0, 0, 1'b1);
    chk("peca_on_rollover", int'(contagem), 1);
    repeat (5) step(1'b0, 0, 0, 0, 1'b1);
    chk("saturate", int'(contagem), 3);
    step(1'b1, 0, 0, 3, 1'b0);
    chk("load_0000_virada", int'(virada_dia), 0);
    chk("load_0000_contagem", int'(contagem), 3);

    step(1'b1, 10, 30, 2, 1'b0);
    idle();
    step(1'b1, 24, 60, 7, 1'b0);
    chk("invalid_hora", int'(hora), 10);
    chk("invalid_dia", int'(dia), 2);
    idle();
    chk("prescaler_restart_hold", int'(minuto), 30);
    idle();
    chk("prescaler_restart_tick", int'(minuto), 31);

    repeat (400) begin
      r = int'($urandom_range(0, 19));
      if (r == 0)
        step(1'b1, int'($urandom_range(0, 26)), int'($urandom_range(0, 63)),
             int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      else if (r == 1)
        step(1'b1, 23, int'($urandom_range(58, 59)), int'($urandom_range(0, 6)),
             1'($urandom_range(0, 1)));
      else
        step(1'b0, 0, 0, 0, 1'($urandom_range(0, 1)));
    end

    step(1'b1, 23, 59, 4, 1'b0);
    idle();
    step(1'b0, 0, 0, 0, 1'b1);
    step(1'b1, 19, 45, 4, 1'b1);
    chk("pre_reset_contagem", int'(contagem), 2);
    chk("pre_reset_minuto", int'(minuto), 45);
    @(negedge clk_2);
    #1 reset_n = 1'b0;
    #1 check_zero("async_reset");
    model_reset();
    @(posedge clk_2);
    #1 check_zero("reset_hold");
    #1 reset_n = 1'b1;
    idle(); idle();
    chk("after_reset_minute", int'(minuto), 1);

    @(negedge clk_2);
    #1 chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
